mac_acc_seq: RTL and testbench
==============================

MAC_ACC_SEQ -- requirements
Module: mac_acc_seq

Interface
REQ-001 SHALL have parameter LEN_W, default 8, width of the beat-count configuration.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  pulse that begins a job; sampled only in IDLE, or in DONE together with an output handshake.
REQ-005 SHALL have port cfg_mode  input  1  1 = INT8 (4 lanes x 32 bit), 0 = INT4 (8 lanes x 16 bit); latched on start.
REQ-006 SHALL have port cfg_len  input  LEN_W  beats per job; latched on start; 0 means 2^LEN_W.
REQ-007 SHALL have port cfg_bias  input  128  initial accumulator, lane-packed; latched on start.
REQ-008 SHALL have port in_valid / in_ready  input / output  1 / 1  operand-beat handshake.
REQ-009 SHALL have port in_a, in_b  input  32 / 32  packed signed operands (4 x INT8 or 8 x INT4).
REQ-010 SHALL have port abort  input  1  synchronous job cancel.
REQ-011 SHALL have port out_valid / out_ready  output / input  1 / 1  result handshake.
REQ-012 SHALL have port out_data  output  128  final accumulator, lane-packed.
REQ-013 SHALL have port out_mode  output  1  mode of the job that produced out_data.
REQ-014 SHALL have port busy  output  1  high in ACC and DONE.

Function
REQ-015 SHALL implement FSM states IDLE, ACC, DONE.
REQ-016 IDLE: in_ready=0, out_valid=0; on start, acc<=cfg_bias, cnt<=0, mode/len latched, next ACC.
REQ-017 ACC: in_ready=1; a beat is accepted when in_valid && in_ready.
REQ-018 On accept, each lane i SHALL update acc_lane <= acc_lane + sext(a_lane * b_lane), signed, modulo 2^32 (INT8) or 2^16 (INT4), no saturation, no carry between lanes.
REQ-019 INT8 lane i uses a[8i+:8], b[8i+:8], acc[32i+:32]; INT4 lane i uses a[4i+:4], b[4i+:4], acc[16i+:16].
REQ-020 On accept with cnt == len-1 (len 0 decoded as 2^LEN_W), next state SHALL be DONE; otherwise cnt increments.
REQ-021 Latency: out_valid SHALL assert the cycle after the last beat is accepted.
REQ-022 DONE: out_valid=1, in_ready=0; out_data and out_mode SHALL be the registered accumulator and mode, held stable until out_ready.
REQ-023 DONE with out_ready && !start: next IDLE; with out_ready && start: new config latched, next ACC (zero-bubble back-to-back).
REQ-024 start in ACC, or in DONE without out_ready, SHALL be ignored.
REQ-025 abort in ACC or DONE SHALL force IDLE next cycle, drop out_valid, discard the accumulator; abort has priority over beats, start and out handshake.
REQ-026 in_a/in_b SHALL NOT affect state when no beat is accepted.

Reset
REQ-027 While rst_n=0: state=IDLE, cnt=0, acc=0, out_data=0, out_mode=0, out_valid=0, in_ready=0, busy=0.
REQ-028 Reset mid-job SHALL discard the job; no partial result is emitted after release.

Structure
REQ-029 Shared package SHALL hold the state enum, mode encodings (MODE_INT4=0, MODE_INT8=1), lane counts and lane widths.
REQ-030 Per-lane multiply-add SHALL be the existing combinational mac_adder block (32/32/128 in, 128 out, mode select), its output registered in this block.

Verification
REQ-031 INT8, bias 0, len 2, two beats a=0x02020202 b=0x03030303 -> out_data=0x0000000C_0000000C_0000000C_0000000C, out_mode=1.
REQ-032 INT4, bias 0, len 3, three beats a=0xFFFFFFFF b=0x11111111 -> every 16-bit lane 0xFFFD, out_mode=0.
REQ-033 INT8 wrap: bias lane0=0x7FFFFFFF, len 1, a=0x00000001 b=0x00000001 -> lane0=0x80000000, other lanes equal bias.
REQ-034 Backpressure: in_valid toggled every cycle, out_ready low 5 cycles -> count correct, out_data stable, in_ready=0 in DONE; start+out_ready in DONE -> next job accepts a beat the following cycle.
REQ-035 cfg_len=0 -> exactly 256 beats accepted before out_valid.
REQ-036 rst_n low or abort after 1 of 4 beats -> IDLE, out_valid never asserts, all outputs at reset values.

Source files
------------

// File: rtl/mac_acc_seq_pkg.sv
// rtl/mac_acc_seq_pkg.sv - shared types and lane geometry for the MAC accumulator
// Contents: FSM state enum, mode encodings, lane counts/widths, bus widths.
package mac_acc_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic MODE_INT4 = 1'b0;
  localparam logic MODE_INT8 = 1'b1;

  localparam int OPND_W = 32;
  localparam int ACC_W  = 128;

  localparam int INT8_LANES  = 4;
  localparam int INT8_OPND_W = 8;
  localparam int INT8_LANE_W = 32;

  localparam int INT4_LANES  = 8;
  localparam int INT4_OPND_W = 4;
  localparam int INT4_LANE_W = 16;

endpackage

// File: rtl/mac_acc_seq_if.sv
// rtl/mac_acc_seq_if.sv - job/operand/result bus of the MAC accumulator
// master: job issuer / operand source / result sink (drives start, cfg_*, in_*, abort, out_ready)
// slave : accumulator (drives in_ready, out_valid, out_data, out_mode, busy)
interface mac_acc_seq_if #(
  parameter int LEN_W = 8
);
  logic             start;
  logic             cfg_mode;
  logic [LEN_W-1:0] cfg_len;
  logic [127:0]     cfg_bias;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic             abort;
  logic             out_valid;
  logic             out_ready;
  logic [127:0]     out_data;
  logic             out_mode;
  logic             busy;

  modport master (
    output start, cfg_mode, cfg_len, cfg_bias, in_valid, in_a, in_b, abort, out_ready,
    input  in_ready, out_valid, out_data, out_mode, busy
  );

  modport slave (
    input  start, cfg_mode, cfg_len, cfg_bias, in_valid, in_a, in_b, abort, out_ready,
    output in_ready, out_valid, out_data, out_mode, busy
  );
endinterface

// File: rtl/mac_adder.sv
// rtl/mac_adder.sv - combinational lane-wise signed multiply-add
// Ports: a_i/b_i packed operands (4 x INT8 or 8 x INT4), acc_i packed accumulator,
//        mode_i lane mode select, sum_o packed acc_i + sext(a*b) per lane (wrapping).
module mac_adder
  import mac_acc_seq_pkg::*;
(
  input  logic [OPND_W-1:0] a_i,
  input  logic [OPND_W-1:0] b_i,
  input  logic [ACC_W-1:0]  acc_i,
  input  logic              mode_i,
  output logic [ACC_W-1:0]  sum_o
);

  // The product is formed in 16/8-bit signed context so operands sign-extend first.
  function automatic logic [INT8_LANE_W-1:0] mac8(input logic [INT8_OPND_W-1:0] a,
                                                  input logic [INT8_OPND_W-1:0] b,
                                                  input logic [INT8_LANE_W-1:0] acc);
    logic signed [15:0] p;
    p = $signed(a) * $signed(b);
    return acc + {{16{p[15]}}, p};
  endfunction

  function automatic logic [INT4_LANE_W-1:0] mac4(input logic [INT4_OPND_W-1:0] a,
                                                  input logic [INT4_OPND_W-1:0] b,
                                                  input logic [INT4_LANE_W-1:0] acc);
    logic signed [7:0] p;
    p = $signed(a) * $signed(b);
    return acc + {{8{p[7]}}, p};
  endfunction

  always_comb begin
    sum_o = '0;
    if (mode_i == MODE_INT8) begin
      for (int i = 0; i < INT8_LANES; i++) begin
        sum_o[INT8_LANE_W*i +: INT8_LANE_W] = mac8(a_i[INT8_OPND_W*i +: INT8_OPND_W],
                                                   b_i[INT8_OPND_W*i +: INT8_OPND_W],
                                                   acc_i[INT8_LANE_W*i +: INT8_LANE_W]);
      end
    end else begin
      for (int i = 0; i < INT4_LANES; i++) begin
        sum_o[INT4_LANE_W*i +: INT4_LANE_W] = mac4(a_i[INT4_OPND_W*i +: INT4_OPND_W],
                                                   b_i[INT4_OPND_W*i +: INT4_OPND_W],
                                                   acc_i[INT4_LANE_W*i +: INT4_LANE_W]);
      end
    end
  end

endmodule

// File: rtl/mac_acc_seq.sv
// rtl/mac_acc_seq.sv - job-sequenced lane-packed signed MAC accumulator
// Ports: clk, rst_n (async active-low); bus (slave): start/cfg_* job launch,
//        in_valid/in_ready/in_a/in_b operand beats, abort, out_valid/out_ready/
//        out_data/out_mode result, busy.
module mac_acc_seq
  import mac_acc_seq_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  mac_acc_seq_if.slave  bus
);

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               mode_q, mode_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   mac_sum;
  logic [LEN_W-1:0]   last_cnt;
  logic               accept;

  mac_adder u_mac_adder (
    .a_i    (bus.in_a),
    .b_i    (bus.in_b),
    .acc_i  (acc_q),
    .mode_i (mode_q),
    .sum_o  (mac_sum)
  );

  // len 0 wraps to all-ones here, which is exactly the last index of a 2^LEN_W job.
  assign last_cnt = len_q - 1'b1;
  assign accept   = bus.in_valid && (state_q == ST_ACC);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    mode_d  = mode_q;
    acc_d   = acc_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_ACC;
          cnt_d   = '0;
          len_d   = bus.cfg_len;
          mode_d  = bus.cfg_mode;
          acc_d   = bus.cfg_bias;
        end
      end
      ST_ACC: begin
        if (accept) begin
          acc_d = mac_sum;
          if (cnt_q == last_cnt) begin
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          if (bus.start) begin
            state_d = ST_ACC;
            cnt_d   = '0;
            len_d   = bus.cfg_len;
            mode_d  = bus.cfg_mode;
            acc_d   = bus.cfg_bias;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort discards the job entirely so the result outputs read as after reset.
    if (bus.abort) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      mode_d  = MODE_INT4;
      acc_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      mode_q  <= MODE_INT4;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      mode_q  <= mode_d;
      acc_q   <= acc_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_ACC);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.out_data  = acc_q;
  assign bus.out_mode  = mode_q;

endmodule

// File: tb/tb_mac_acc_seq.sv
// tb/tb_mac_acc_seq.sv - directed self-checking bench for mac_acc_seq
module tb_mac_acc_seq;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mac_acc_seq_if #(.LEN_W(8)) bus ();

  mac_acc_seq #(.LEN_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic start_job(input logic mode, input logic [7:0] len, input logic [127:0] bias);
    bus.cfg_mode = mode;
    bus.cfg_len  = len;
    bus.cfg_bias = bias;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout: in_ready=%0b required 1", bus.in_ready);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic ack_result();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %0b want 0", bus.in_ready); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", bus.busy); end
    checks++; if (bus.out_data !== 128'h0) begin errors++; $display("FAIL reset_out_data: got %h want 0", bus.out_data); end
    checks++; if (bus.out_mode !== 1'b0) begin errors++; $display("FAIL reset_out_mode: got %0b want 0", bus.out_mode); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_int8_basic();
    start_job(1'b1, 8'd2, 128'h0);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL int8_in_ready: got %0b want 1", bus.in_ready); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL int8_busy: got %0b want 1", bus.busy); end
    send_beat(32'h02020202, 32'h03030303);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL int8_early_valid: got %0b want 0", bus.out_valid); end
    send_beat(32'h02020202, 32'h03030303);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL int8_latency: out_valid=%0b want 1", bus.out_valid); end
    checks++; if (bus.out_data !== 128'h0000000C_0000000C_0000000C_0000000C) begin errors++; $display("FAIL int8_data: got %h want 0000000c0000000c0000000c0000000c", bus.out_data); end
    checks++; if (bus.out_mode !== 1'b1) begin errors++; $display("FAIL int8_mode: got %0b want 1", bus.out_mode); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL int8_done_in_ready: got %0b want 0", bus.in_ready); end
    ack_result();
    checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL int8_idle_after_ack: out_valid=%0b busy=%0b want 0 0", bus.out_valid, bus.busy); end
  endtask

  task automatic test_int4_basic();
    start_job(1'b0, 8'd3, 128'h0);
    repeat (3) send_beat(32'hFFFFFFFF, 32'h11111111);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL int4_valid: got %0b want 1", bus.out_valid); end
    checks++; if (bus.out_data !== {8{16'hFFFD}}) begin errors++; $display("FAIL int4_data: got %h want %h", bus.out_data, {8{16'hFFFD}}); end
    checks++; if (bus.out_mode !== 1'b0) begin errors++; $display("FAIL int4_mode: got %0b want 0", bus.out_mode); end
    ack_result();
  endtask

  task automatic test_int8_wrap();
    start_job(1'b1, 8'd1, 128'h11111111_22222222_33333333_7FFFFFFF);
    send_beat(32'h00000001, 32'h00000001);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid: got %0b want 1", bus.out_valid); end
    checks++; if (bus.out_data !== 128'h11111111_22222222_33333333_80000000) begin errors++; $display("FAIL wrap_data: got %h want 11111111222222223333333380000000", bus.out_data); end
    ack_result();
  endtask

  task automatic test_back_to_back();
    int accepts;
    int cyc;
    logic [127:0] exp_data;
    exp_data = 128'h00000004_00000008_0000000C_00000010;
    accepts  = 0;
    cyc      = 0;
    start_job(1'b1, 8'd4, 128'h0);
    bus.in_a = 32'h01020304;
    bus.in_b = 32'h01010101;
    while (!bus.out_valid && cyc < 100) begin
      bus.in_valid = (cyc % 2 == 0);
      if (bus.in_valid && bus.in_ready) accepts++;
      @(negedge clk);
      cyc++;
    end
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_timeout: out_valid=%0b want 1", bus.out_valid); end
    checks++; if (accepts != 4) begin errors++; $display("FAIL bp_beat_count: got %0d want 4", accepts); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_ctrl: out_valid=%0b in_ready=%0b want 1 0", bus.out_valid, bus.in_ready); end
      checks++; if (bus.out_data !== exp_data) begin errors++; $display("FAIL bp_hold_data: got %h want %h", bus.out_data, exp_data); end
      bus.start    = 1'b1;
      bus.cfg_len  = 8'd7;
      @(negedge clk);
      bus.start    = 1'b0;
    end
    bus.cfg_mode  = 1'b1;
    bus.cfg_len   = 8'd1;
    bus.cfg_bias  = 128'h5;
    bus.start     = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.start     = 1'b0;
    bus.out_ready = 1'b0;
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_restart: in_ready=%0b out_valid=%0b want 1 0", bus.in_ready, bus.out_valid); end
    send_beat(32'h00000002, 32'h00000002);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 128'h9) begin errors++; $display("FAIL b2b_result: out_valid=%0b data=%h want 1 9", bus.out_valid, bus.out_data); end
    ack_result();
  endtask

  task automatic test_len_zero();
    int accepts;
    int cyc;
    accepts = 0;
    cyc     = 0;
    start_job(1'b0, 8'd0, 128'h0);
    bus.in_a     = 32'h00000001;
    bus.in_b     = 32'h00000001;
    bus.in_valid = 1'b1;
    while (!bus.out_valid && cyc < 400) begin
      if (bus.in_ready) accepts++;
      @(negedge clk);
      cyc++;
    end
    bus.in_valid = 1'b0;
    checks++; if (accepts != 256) begin errors++; $display("FAIL len0_beat_count: got %0d want 256", accepts); end
    checks++; if (bus.out_data !== 128'h0100) begin errors++; $display("FAIL len0_data: got %h want 100", bus.out_data); end
    ack_result();
  endtask

  task automatic test_abort();
    logic seen;
    seen = 1'b0;
    start_job(1'b1, 8'd4, 128'h0);
    send_beat(32'h01010101, 32'h01010101);
    bus.abort = 1'b1;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    bus.in_valid = 1'b0;
    checks++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL abort_ctrl: busy=%0b in_ready=%0b out_valid=%0b want 0 0 0", bus.busy, bus.in_ready, bus.out_valid); end
    checks++; if (bus.out_data !== 128'h0 || bus.out_mode !== 1'b0) begin errors++; $display("FAIL abort_outputs: data=%h mode=%0b want 0 0", bus.out_data, bus.out_mode); end
    repeat (6) begin
      if (bus.out_valid) seen = 1'b1;
      @(negedge clk);
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_result: out_valid seen=%0b want 0", seen); end
  endtask

  task automatic test_reset_midjob();
    logic seen;
    seen = 1'b0;
    start_job(1'b1, 8'd4, 128'h0);
    send_beat(32'h01010101, 32'h01010101);
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || bus.out_data !== 128'h0 || bus.out_mode !== 1'b0) begin errors++; $display("FAIL rst_mid_outputs: busy=%0b data=%h mode=%0b want 0 0 0", bus.busy, bus.out_data, bus.out_mode); end
    rst_n = 1'b1;
    bus.in_valid = 1'b1;
    repeat (6) begin
      if (bus.out_valid || bus.in_ready) seen = 1'b1;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_mid_no_result: activity seen=%0b want 0", seen); end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.cfg_mode  = 1'b0;
    bus.cfg_len   = 8'd0;
    bus.cfg_bias  = 128'h0;
    bus.in_valid  = 1'b0;
    bus.in_a      = 32'h0;
    bus.in_b      = 32'h0;
    bus.abort     = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_int8_basic();
    test_int4_basic();
    test_int8_wrap();
    test_back_to_back();
    test_len_zero();
    test_abort();
    test_reset_midjob();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
